// File: rtl/ascii_int_counter.sv
// Multi-digit up/down counter in a configurable radix. Each digit is presented as an ASCII byte.
// A byte serializer streams a snapshot of the count, most significant digit first.
module ascii_int_counter #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BASE       = 10,
  parameter bit          LZ_BLANK   = 1'b0,
  parameter bit          APPEND_EOL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clr,
  output logic [8*NUM_DIGITS-1:0] value,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    emit,
  output logic                    busy,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_last
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : gen_bad_num_digits
    $error("ascii_int_counter: NUM_DIGITS must be in 1..8");
  end
  if (BASE < 2 || BASE > 16) begin : gen_bad_base
    $error("ascii_int_counter: BASE must be in 2..16");
  end

  localparam logic [3:0] MaxDigit = 4'(BASE - 1);
  localparam logic [2:0] MsdIdx   = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StCr, StLf} state_e;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  logic [NUM_DIGITS-1:0][3:0] cnt_q, cnt_d;
  logic [8*NUM_DIGITS-1:0]    value_d;
  logic                       ovf_d, unf_d, carry;

  // Snapshot is padded to 8 digits so the 3-bit digit index never leaves the array.
  logic [7:0][3:0]            snap_q, snap_d;
  logic [2:0]                 idx_q, idx_d, start_idx;
  state_e                     state_q, state_d;

  // Next count: clr wins, inc/dec ripple carry or borrow through all digits in one cycle.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    carry = 1'b1;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (carry) begin
          if (cnt_q[i] == MaxDigit) begin
            cnt_d[i] = 4'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
      ovf_d = carry;
    end else if (dec && !inc) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (carry) begin
          if (cnt_q[i] == 4'd0) begin
            cnt_d[i] = MaxDigit;
          end else begin
            cnt_d[i] = cnt_q[i] - 4'd1;
            carry    = 1'b0;
          end
        end
      end
      unf_d = carry;
    end
  end

  // ASCII view of the next count, registered alongside the digits.
  always_comb begin
    value_d = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      value_d[8*i +: 8] = to_ascii(cnt_d[i]);
    end
  end

  // Counter state, ASCII value and wrap pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      value     <= {NUM_DIGITS{8'h30}};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      value     <= value_d;
      overflow  <= ovf_d;
      underflow <= unf_d;
    end
  end

  // First digit to send: MSD, or the highest non-zero digit when blanking (LSD for zero).
  always_comb begin
    start_idx = MsdIdx;
    if (LZ_BLANK) begin
      start_idx = 3'd0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (cnt_q[i] != 4'd0) start_idx = 3'(i);
      end
    end
  end

  // Serializer next state and byte-port outputs; outputs depend on registered state only.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    busy     = (state_q != StIdle);
    tx_valid = (state_q != StIdle);
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (emit) begin
          state_d                   = StSend;
          idx_d                     = start_idx;
          snap_d                    = '0;
          snap_d[NUM_DIGITS-1:0]    = cnt_q;
        end
      end
      StSend: begin
        tx_data = to_ascii(snap_q[idx_q]);
        tx_last = (idx_q == 3'd0) && !APPEND_EOL;
        if (tx_ready) begin
          if (idx_q == 3'd0) state_d = APPEND_EOL ? StCr : StIdle;
          else               idx_d   = idx_q - 3'd1;
        end
      end
      StCr: begin
        tx_data = 8'h0D;
        if (tx_ready) state_d = StLf;
      end
      StLf: begin
        tx_data = 8'h0A;
        tx_last = 1'b1;
        if (tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Serializer registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

endmodule

// File: tb/tb_ascii_int_counter.sv
// Bench for ascii_int_counter: three instances (decimal, hex, decimal with blanking and EOL).
module tb_ascii_int_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[3], inc[3], dec[3], clr[3], emit[3], tx_ready[3];
  logic [31:0] value[3];
  logic        overflow[3], underflow[3], busy[3], tx_valid[3], tx_last[3];
  logic [7:0]  tx_data[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ascii_int_counter #(
      .NUM_DIGITS(4),
      .BASE      ((g == 1) ? 16 : 10),
      .LZ_BLANK  ((g == 2) ? 1'b1 : 1'b0),
      .APPEND_EOL((g == 2) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .inc      (inc[g]),
      .dec      (dec[g]),
      .clr      (clr[g]),
      .value    (value[g]),
      .overflow (overflow[g]),
      .underflow(underflow[g]),
      .emit     (emit[g]),
      .busy     (busy[g]),
      .tx_data  (tx_data[g]),
      .tx_valid (tx_valid[g]),
      .tx_ready (tx_ready[g]),
      .tx_last  (tx_last[g])
    );
  end

  int          n_total = 0;
  int          n_bad   = 0;
  int          sel     = 0;
  int unsigned m[3];
  logic [8:0]  exp_q[$];  // {last, byte}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned base_of(input int k);
    return (k == 1) ? 16 : 10;
  endfunction

  function automatic logic [31:0] asc(input int unsigned n, input int unsigned b);
    logic [31:0] r;
    int unsigned pw, dg;
    r  = '0;
    pw = 1;
    for (int j = 0; j < 4; j++) begin
      dg = (n / pw) % b;
      r[j*8 +: 8] = (dg < 10) ? 8'(32'h30 + dg) : 8'(32'h37 + dg);
      pw = pw * b;
    end
    return r;
  endfunction

  // One cycle of counter stimulus on instance k, then compare against the model.
  task automatic step(input int k, input logic i, input logic d, input logic c);
    int unsigned b, md;
    logic o, u;
    b  = base_of(k);
    md = b * b * b * b;
    o  = 1'b0;
    u  = 1'b0;
    inc[k] = i; dec[k] = d; clr[k] = c;
    tick();
    inc[k] = 1'b0; dec[k] = 1'b0; clr[k] = 1'b0;
    if (c) m[k] = 0;
    else if (i && !d) begin
      if (m[k] == md - 1) begin m[k] = 0; o = 1'b1; end
      else m[k]++;
    end else if (d && !i) begin
      if (m[k] == 0) begin m[k] = md - 1; u = 1'b1; end
      else m[k]--;
    end
    check("value", value[k], asc(m[k], b));
    check("overflow", 32'(overflow[k]), 32'(o));
    check("underflow", 32'(underflow[k]), 32'(u));
  endtask

  // Expected frame for a snapshot n on instance k.
  task automatic push_frame(input int k, input int unsigned n, input bit lz, input bit eol);
    logic [31:0] a;
    int top;
    a   = asc(n, base_of(k));
    top = 3;
    if (lz) begin
      top = 0;
      for (int j = 0; j < 4; j++) if (a[j*8 +: 8] != 8'h30) top = j;
    end
    for (int j = top; j >= 0; j--) exp_q.push_back({(j == 0) && !eol, a[j*8 +: 8]});
    if (eol) begin
      exp_q.push_back({1'b0, 8'h0D});
      exp_q.push_back({1'b1, 8'h0A});
    end
  endtask

  // Byte monitor: every valid byte must match the scoreboard head; pop on acceptance.
  always @(negedge clk) begin
    if (tx_valid[sel] === 1'b1) begin
      check("tx_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("tx_byte", {23'd0, tx_last[sel], tx_data[sel]}, {23'd0, exp_q[0]});
        if (tx_ready[sel] === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; inc[k] = 1'b0; dec[k] = 1'b0; clr[k] = 1'b0;
      emit[k] = 1'b0; tx_ready[k] = 1'b0; m[k] = 0;
    end

    // Reset held two cycles.
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_value", value[k], 32'h30303030);
      check("rst_ovf", 32'(overflow[k]), 32'd0);
      check("rst_unf", 32'(underflow[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_valid", 32'(tx_valid[k]), 32'd0);
      check("rst_last", 32'(tx_last[k]), 32'd0);
      check("rst_data", 32'(tx_data[k]), 32'd0);
      rst[k] = 1'b0;
    end

    // Wrap both ways in decimal: 0 -> 9999 -> 0000 -> 9999, pulses last one cycle.
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0);

    // Hex: reach 00AF, carry into 00B0, inc&dec no-op, clr beats inc.
    for (int n = 0; n < 175; n++) step(1, 1'b1, 1'b0, 1'b0);
    check("hex_00AF", value[1], 32'h30304146);
    step(1, 1'b1, 1'b0, 1'b0);
    check("hex_00B0", value[1], 32'h30304230);
    step(1, 1'b1, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0, 1'b1);
    check("hex_clr", value[1], 32'h30303030);

    // Blanked frame with EOL under random back-pressure.
    sel = 2;
    for (int n = 0; n < 42; n++) step(2, 1'b1, 1'b0, 1'b0);
    push_frame(2, m[2], 1'b1, 1'b1);
    emit[2] = 1'b1;
    tick();
    emit[2] = 1'b0;
    check("f4_busy", 32'(busy[2]), 32'd1);
    for (int c = 0; c < 100; c++) begin
      tx_ready[2] = 1'($urandom_range(0, 1));
      tick();
      if (!busy[2]) break;
    end
    tx_ready[2] = 1'b0;
    check("f4_done", 32'(busy[2]), 32'd0);
    check("f4_drained", 32'(exp_q.size()), 32'd0);

    // Unblanked zero frame while counting, with emit pulses during the frame.
    sel = 0;
    step(0, 1'b0, 1'b0, 1'b1);
    push_frame(0, m[0], 1'b0, 1'b0);
    emit[0] = 1'b1;
    inc[0]  = 1'b1;
    tick();
    m[0]++;
    for (int c = 0; c < 100; c++) begin
      tx_ready[0] = 1'($urandom_range(0, 1));
      emit[0]     = busy[0] & c[0];
      tick();
      m[0] = (m[0] + 1) % 10000;
      if (!busy[0]) break;
    end
    inc[0] = 1'b0; emit[0] = 1'b0; tx_ready[0] = 1'b0;
    check("f5_value", value[0], asc(m[0], 10));
    check("f5_drained", 32'(exp_q.size()), 32'd0);
    for (int c = 0; c < 4; c++) tick();
    check("f5_no_extra", 32'(busy[0]), 32'd0);

    // Reset after the second accepted byte aborts the frame.
    push_frame(0, m[0], 1'b0, 1'b0);
    tx_ready[0] = 1'b1;
    emit[0]     = 1'b1;
    tick();
    emit[0] = 1'b0;
    tick();
    tick();
    check("f6_remaining", 32'(exp_q.size()), 32'd2);
    tx_ready[0] = 1'b0;
    rst[0]      = 1'b1;
    tick();
    rst[0] = 1'b0;
    m[0]   = 0;
    exp_q.delete();
    check("f6_valid", 32'(tx_valid[0]), 32'd0);
    check("f6_busy", 32'(busy[0]), 32'd0);
    check("f6_last", 32'(tx_last[0]), 32'd0);
    check("f6_value", value[0], 32'h30303030);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
